rr_arbiter_4to2: RTL and testbench

- Four-requester round-robin arbiter that shares one resource slot.
- Uses a rotating-priority 4-to-2 encoder for the grant decision, plus registered grant state, a hold counter and a rotation pointer.
- Outputs a one-hot grant and the matching 2-bit encoded owner ID, so downstream muxes can steer data directly.
- Sits between the request sources and the shared datapath. Bounds each tenure so no requester is starved.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_pick4.sv | 30 +++
 rtl/rr_arbiter_4to2.sv | 106 ++++++++++
 tb/tb_rr_arbiter_4to2.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants and state type for the 4-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority 4-to-2 encoder: scans req upward from base (mod 4), first set bit wins.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  base,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    logic [N_REQ-1:0] rot_s;
    logic [2:0]       sel_s;

    // Rotate so that position 0 is the base requester, then take the lowest set position.
    always_comb begin
        rot_s = 4'b0000;
        sel_s = 3'd4;
        for (int k = 0; k < N_REQ; k++) begin
            rot_s[k] = req[base + 2'(k)];
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sel_s = rot_s[k] ? 3'(k) : sel_s;
        end
        any    = (sel_s != 3'd4);
        id     = any ? (base + sel_s[1:0]) : 2'd0;
        onehot = any ? (4'b0001 << id) : 4'b0000;
    end

endmodule

// File: rtl/rr_arbiter_4to2.sv
// Four-requester round-robin arbiter with bounded tenure and a registered one-hot grant.
module rr_arbiter_4to2
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  hold_q, hold_d;

    logic              release_s;
    logic [ID_W-1:0]   base_s;
    logic [N_REQ-1:0]  pick_onehot_s;
    logic [ID_W-1:0]   pick_id_s;
    logic              pick_any_s;

    // On release the re-pick starts just past the current owner, so the owner is scanned last.
    assign release_s = (~req[gnt_id_q]) | (hold_q == HOLD_LAST);
    assign base_s    = (state_q == BUSY) ? (gnt_id_q + 2'd1) : ptr_q;

    rr_pick4 u_pick (
        .req    (req),
        .base   (base_s),
        .onehot (pick_onehot_s),
        .id     (pick_id_s),
        .any    (pick_any_s)
    );

    // Next-state logic: grant from IDLE, hold or hand off (without a bubble) from BUSY.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d  = BUSY;
                    gnt_d    = pick_onehot_s;
                    gnt_id_d = pick_id_s;
                    hold_d   = {CNT_W{1'b0}};
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    ptr_d  = gnt_id_q + 2'd1;
                    hold_d = {CNT_W{1'b0}};
                    if (pick_any_s) begin
                        gnt_d    = pick_onehot_s;
                        gnt_id_d = pick_id_s;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = 4'b0000;
                        gnt_id_d = 2'd0;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = 4'b0000;
                gnt_id_d = 2'd0;
                hold_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            ptr_q    <= 2'd0;
            hold_q   <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter_4to2.sv
// Randomized bench for rr_arbiter_4to2: two instances (MAX_HOLD 8 and 3) against a tenure-count model.
module tb_rr_arbiter_4to2;

    localparam int MH_A = 8;
    localparam int MH_B = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       v_a, v_b;

    int n_cmp = 0;
    int n_mis = 0;

    int m_owner[2];
    int m_ten[2];
    int m_ptr[2];
    int m_max[2] = '{MH_A, MH_B};

    always #5 clk = ~clk;

    rr_arbiter_4to2 #(.MAX_HOLD(MH_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(v_a)
    );

    rr_arbiter_4to2 #(.MAX_HOLD(MH_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(v_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int base);
        for (int k = 0; k < 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_ten[m]   = 0;
            m_ptr[m]   = 0;
        end
    endtask

    // Tenure is counted in granted cycles; an owner leaves after m_max cycles or when it drops req.
    task automatic model_edge(input logic [3:0] r);
        int p;
        for (int m = 0; m < 2; m++) begin
            if (m_owner[m] < 0) begin
                p = pick(r, m_ptr[m]);
                if (p >= 0) begin
                    m_owner[m] = p;
                    m_ten[m]   = 1;
                end
            end else if (!r[m_owner[m]] || m_ten[m] == m_max[m]) begin
                m_ptr[m] = (m_owner[m] + 1) % 4;
                p = pick(r, m_ptr[m]);
                m_owner[m] = p;
                m_ten[m]   = (p >= 0) ? 1 : 0;
            end else begin
                m_ten[m]++;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        int eg[2];
        int ei[2];
        for (int m = 0; m < 2; m++) begin
            eg[m] = (m_owner[m] < 0) ? 0 : (1 << m_owner[m]);
            ei[m] = (m_owner[m] < 0) ? 0 : m_owner[m];
        end
        check_eq({ctx, "/gnt_a"}, 32'(gnt_a), eg[0]);
        check_eq({ctx, "/id_a"},  32'(id_a),  ei[0]);
        check_eq({ctx, "/vld_a"}, 32'(v_a),   (eg[0] != 0) ? 1 : 0);
        check_eq({ctx, "/gnt_b"}, 32'(gnt_b), eg[1]);
        check_eq({ctx, "/id_b"},  32'(id_b),  ei[1]);
        check_eq({ctx, "/vld_b"}, 32'(v_b),   (eg[1] != 0) ? 1 : 0);
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_all("step");
    endtask

    // Assert reset between edges and check the outputs clear before the next rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b1111;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        step(4'b1111);
        check_eq("first_gnt", 32'(gnt_a), 32'd1);
        check_eq("first_id", 32'(id_a), 32'd0);
        for (int i = 0; i < 40; i++) step(4'b1111);

        do_reset();
        step(4'b0100);
        check_eq("single_gnt", 32'(gnt_a), 32'd4);
        check_eq("single_id", 32'(id_a), 32'd2);
        repeat (3) step(4'b0100);
        step(4'b0000);
        check_eq("single_drop", 32'(v_a), 32'd0);

        do_reset();
        step(4'b0010);
        step(4'b1111);
        step(4'b1101);
        check_eq("handoff_gnt", 32'(gnt_a), 32'd4);
        check_eq("handoff_id", 32'(id_a), 32'd2);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0001);
            check_eq("sole_a", 32'(gnt_a), 32'd1);
            check_eq("sole_b", 32'(gnt_b), 32'd1);
        end

        do_reset();
        step(4'b1000);
        step(4'b1000);
        check_eq("pre_rst", 32'(gnt_a), 32'd8);
        do_reset();
        step(4'b1010);
        check_eq("post_rst", 32'(gnt_a), 32'd2);

        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset();
            step(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
